// File: rtl/mem_bus_arbiter_pkg.sv
// Shared CPU defines for the memory bus arbiter: state encoding, word types
// and the bus timeout length used when BUS_TIMEOUT_EN is defined.
package mem_bus_arbiter_pkg;

  typedef logic [31:0] Word_t;
  typedef logic        Bit_t;
  typedef logic [3:0]  Sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int unsigned BUS_TIMEOUT_CYCLES = 255;
  localparam int unsigned TIMEOUT_CNT_W      = 8;

  localparam Sel_t  SEL_NONE = 4'b0000;
  localparam Sel_t  SEL_ALL  = 4'b1111;
  localparam Word_t WORD_ZERO = 32'h0000_0000;

  // True while a bus transfer is outstanding and the watchdog should run.
  function automatic Bit_t is_bus_state(input arb_state_e s);
    return (s == DATA) || (s == INST);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Cycle counter that fires a one-cycle expired pulse once a bus transfer has
// been outstanding for BUS_TIMEOUT_CYCLES cycles; idles at zero otherwise.
module bus_watchdog
  import mem_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);

  localparam logic [TIMEOUT_CNT_W-1:0] CNT_LAST = TIMEOUT_CNT_W'(BUS_TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;

  assign expired = active && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (active && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (data over instruction) arbiter onto a single ack-based memory
// bus. Define BUS_TIMEOUT_EN to abort unacknowledged transfers via bus_watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_ready_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,

  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,

  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  arb_state_e state_q, state_d;

  Bit_t  bus_req_q, bus_req_d;
  Bit_t  bus_we_q, bus_we_d;
  Sel_t  bus_sel_q, bus_sel_d;
  Word_t bus_addr_q, bus_addr_d;
  Word_t bus_wdata_q, bus_wdata_d;
  Word_t inst_rdata_q, inst_rdata_d;
  Word_t data_rdata_q, data_rdata_d;
  Bit_t  inst_ready_q, inst_ready_d;
  Bit_t  data_ready_q, data_ready_d;
  Bit_t  discard_q, discard_d;
  Bit_t  bus_err_q, bus_err_d;

  Bit_t  bus_timeout;
  Bit_t  bus_done;
  Word_t bus_rdata_eff;

`ifdef BUS_TIMEOUT_EN
  Bit_t wd_expired;

  bus_watchdog u_bus_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (is_bus_state(state_q)),
    .expired (wd_expired)
  );

  // A real ack in the expiry cycle wins; the timeout only fires without one.
  assign bus_timeout = wd_expired & ~bus_ack_i;
`else
  assign bus_timeout = 1'b0;
`endif

  assign bus_done      = bus_ack_i | bus_timeout;
  assign bus_rdata_eff = bus_ack_i ? bus_rdata_i : WORD_ZERO;

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= SEL_NONE;
      bus_addr_q   <= WORD_ZERO;
      bus_wdata_q  <= WORD_ZERO;
      inst_rdata_q <= WORD_ZERO;
      data_rdata_q <= WORD_ZERO;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      discard_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      discard_q    <= discard_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          state_d = DATA;
        end else if (inst_req_i) begin
          state_d = INST;
        end
      end
      DATA, INST: begin
        if (bus_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    discard_d    = discard_q;
    bus_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          bus_req_d   = 1'b1;
          bus_we_d    = data_we_i;
          bus_sel_d   = data_sel_i;
          bus_addr_d  = data_addr_i;
          bus_wdata_d = data_wdata_i;
        end else if (inst_req_i) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = SEL_ALL;
          bus_addr_d  = inst_addr_i;
          bus_wdata_d = WORD_ZERO;
          discard_d   = flush_i;
        end
      end
      DATA: begin
        if (bus_done) begin
          bus_req_d    = 1'b0;
          data_rdata_d = bus_rdata_eff;
          data_ready_d = 1'b1;
          bus_err_d    = bus_timeout;
        end
      end
      INST: begin
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (bus_done) begin
          bus_req_d = 1'b0;
          bus_err_d = bus_timeout;
          discard_d = 1'b0;
          // A flush landing in the completing cycle still kills the fetch.
          if (!(discard_q || flush_i)) begin
            inst_rdata_d = bus_rdata_eff;
            inst_ready_d = 1'b1;
          end
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_sel_o    = bus_sel_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign inst_ready_o = inst_ready_q;
  assign data_ready_o = data_ready_q;
  assign bus_err_o    = bus_err_q;

  assign stallreq_o = (inst_req_i & ~inst_ready_q) | (data_req_i & ~data_ready_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; the timeout scenario follows
// BUS_TIMEOUT_EN the same way the design does.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_rdata_o;
  logic        inst_ready_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req_i   (inst_req_i),
    .inst_addr_i  (inst_addr_i),
    .inst_rdata_o (inst_rdata_o),
    .inst_ready_o (inst_ready_o),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_sel_i   (data_sel_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_ready_o (data_ready_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_sel_o    (bus_sel_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rdata_i  (bus_rdata_i),
    .bus_ack_i    (bus_ack_i),
    .flush_i      (flush_i),
    .stallreq_o   (stallreq_o),
    .bus_err_o    (bus_err_o)
  );

  int checks_cnt = 0;
  int fail_cnt   = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for the bus request, checks the latched request and its stability,
  // then returns one ack; exits at the negedge where ready should be visible.
  task automatic serve_bus(input int exp_lat, input int wait_cyc, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_sel,
                           input logic [31:0] e_wdata, input bit chk_wdata);
    int n;
    tick();
    n = 1;
    while (!bus_req_o && n < 20) begin
      tick();
      n++;
    end
    check_eq("bus_req_rise", 32'(bus_req_o), 32'd1);
    check_eq("grant_latency", 32'(n), 32'(exp_lat));
    check_eq("bus_addr", bus_addr_o, e_addr);
    check_eq("bus_we", 32'(bus_we_o), 32'(e_we));
    check_eq("bus_sel", 32'(bus_sel_o), 32'(e_sel));
    if (chk_wdata) check_eq("bus_wdata", bus_wdata_o, e_wdata);
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      check_eq("hold_req", 32'(bus_req_o), 32'd1);
      check_eq("hold_addr", bus_addr_o, e_addr);
      check_eq("hold_we_sel", {27'd0, bus_we_o, bus_sel_o}, {27'd0, e_we, e_sel});
      if (chk_wdata) check_eq("hold_wdata", bus_wdata_o, e_wdata);
      check_eq("stall_wait", 32'(stallreq_o), 32'd1);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = rdata;
    tick();
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'hA5A5_5A5A;
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (e.is_data) begin
        check_eq("data_ready", 32'(data_ready_o), 32'd1);
        check_eq("inst_ready_idle", 32'(inst_ready_o), 32'd0);
        check_eq("data_rdata", data_rdata_o, e.rdata);
      end else begin
        check_eq("inst_ready", 32'(inst_ready_o), 32'd1);
        check_eq("data_ready_idle", 32'(data_ready_o), 32'd0);
        check_eq("inst_rdata", inst_rdata_o, e.rdata);
      end
      check_eq("bus_err", 32'(bus_err_o), 32'(e.err));
      $display("txn %s rdata=%h err=%0d data_ready=%0d inst_ready=%0d", e.is_data ? "data" : "inst",
               e.is_data ? data_rdata_o : inst_rdata_o, bus_err_o, data_ready_o, inst_ready_o);
    end
  endtask

  task automatic do_data(input int exp_lat, input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int wait_cyc);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_sel_i   = sel;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    exp_q.push_back('{is_data: 1'b1, rdata: rdata, err: 1'b0});
    serve_bus(exp_lat, wait_cyc, rdata, addr, we, sel, wdata, 1'b1);
    pop_check();
    check_eq("data_stall_at_ready", 32'(stallreq_o), 32'd0);
    data_req_i = 1'b0;
    tick();
    check_eq("data_ready_pulse", 32'(data_ready_o), 32'd0);
    check_eq("data_rdata_hold", data_rdata_o, rdata);
  endtask

  task automatic do_inst(input logic [31:0] addr, input logic [31:0] rdata, input int wait_cyc);
    inst_req_i  = 1'b1;
    inst_addr_i = addr;
    exp_q.push_back('{is_data: 1'b0, rdata: rdata, err: 1'b0});
    serve_bus(1, wait_cyc, rdata, addr, 1'b0, 4'b1111, 32'd0, 1'b0);
    pop_check();
    check_eq("inst_stall_at_ready", 32'(stallreq_o), 32'd0);
    inst_req_i = 1'b0;
    tick();
    check_eq("inst_ready_pulse", 32'(inst_ready_o), 32'd0);
    check_eq("inst_rdata_hold", inst_rdata_o, rdata);
  endtask

  initial begin
    int n;
    bit saw_ready;
    logic [31:0] r;

    rst = 1'b1;
    inst_req_i = 1'b0; inst_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_sel_i = '0; data_addr_i = '0; data_wdata_i = '0;
    bus_rdata_i = 32'hA5A5_5A5A; bus_ack_i = 1'b0; flush_i = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_bus_req", 32'(bus_req_o), 32'd0);
    check_eq("rst_bus_we_sel", {27'd0, bus_we_o, bus_sel_o}, 32'd0);
    check_eq("rst_bus_addr", bus_addr_o, 32'd0);
    check_eq("rst_bus_wdata", bus_wdata_o, 32'd0);
    check_eq("rst_rdata", data_rdata_o | inst_rdata_o, 32'd0);
    check_eq("rst_flags", {28'd0, inst_ready_o, data_ready_o, bus_err_o, stallreq_o}, 32'd0);
    rst = 1'b0;

    // Read, write and fetch with fixed patterns
    do_data(1, 1'b0, 4'b1111, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2);
    do_data(1, 1'b1, 4'b0011, 32'h8000_0020, 32'h1234_5678, 32'h0000_0000, 3);
    do_inst(32'h0000_1000, 32'h1357_9BDF, 0);

    // Random mix of single transactions
    for (int k = 0; k < 6; k++) begin
      r = $urandom;
      if ($urandom_range(1, 0) == 1)
        do_data(1, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 1)), $urandom, $urandom, r,
                int'($urandom_range(3, 0)));
      else
        do_inst($urandom, r, int'($urandom_range(3, 0)));
    end

    // Simultaneous requests: data first, DONE gap, then inst
    data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'b1111;
    data_addr_i = 32'h8000_0040; data_wdata_i = 32'h0;
    inst_req_i = 1'b1; inst_addr_i = 32'h0000_2000;
    exp_q.push_back('{is_data: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0});
    exp_q.push_back('{is_data: 1'b0, rdata: 32'hCAFE_0002, err: 1'b0});
    serve_bus(1, 1, 32'hCAFE_0001, 32'h8000_0040, 1'b0, 4'b1111, 32'h0, 1'b1);
    pop_check();
    check_eq("simul_stall_after_data", 32'(stallreq_o), 32'd1);
    data_req_i = 1'b0;
    tick();
    check_eq("simul_done_bus_req", 32'(bus_req_o), 32'd0);
    check_eq("simul_done_stall", 32'(stallreq_o), 32'd1);
    serve_bus(1, 1, 32'hCAFE_0002, 32'h0000_2000, 1'b0, 4'b1111, 32'h0, 1'b0);
    pop_check();
    check_eq("simul_stall_at_inst", 32'(stallreq_o), 32'd0);
    inst_req_i = 1'b0;
    tick();

    // Flushed fetch: bus completes, no ready, next request granted 2 cycles on
    inst_req_i = 1'b1; inst_addr_i = 32'h0000_3000;
    tick();
    check_eq("flush_bus_req", 32'(bus_req_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; inst_req_i = 1'b0;
    check_eq("flush_bus_held", 32'(bus_req_o), 32'd1);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'hA5A5_5A5A;
    check_eq("flush_no_ready", 32'(inst_ready_o), 32'd0);
    check_eq("flush_bus_done", 32'(bus_req_o), 32'd0);
    do_data(2, 1'b0, 4'b1111, 32'h8000_0050, 32'h0, 32'h7777_0001, 0);

    // Flush has no effect on a data transfer
    flush_i = 1'b1;
    do_data(1, 1'b0, 4'b1100, 32'h8000_0060, 32'h0, 32'h7777_0002, 1);
    flush_i = 1'b0;

    // Reset in the middle of a data transfer
    data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'b1111; data_addr_i = 32'h8000_0070;
    tick();
    check_eq("rstmid_bus_req", 32'(bus_req_o), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_eq("rstmid_req_drop", 32'(bus_req_o), 32'd0);
    check_eq("rstmid_no_ready", 32'(data_ready_o), 32'd0);
    rst = 1'b0; data_req_i = 1'b0;
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'hA5A5_5A5A;
    check_eq("late_ack_no_ready", 32'(data_ready_o), 32'd0);
    check_eq("late_ack_no_req", 32'(bus_req_o), 32'd0);
    tick();
    check_eq("late_ack_rdata", data_rdata_o, 32'd0);
    check_eq("late_ack_no_ready2", 32'(data_ready_o), 32'd0);

    // Transfer that is never acknowledged
    data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'b1111; data_addr_i = 32'h8000_0080;
    tick();
    check_eq("to_bus_req", 32'(bus_req_o), 32'd1);
`ifdef BUS_TIMEOUT_EN
    exp_q.push_back('{is_data: 1'b1, rdata: 32'h0, err: 1'b1});
    n = 0;
    while (bus_req_o && n < 400) begin
      n++;
      tick();
    end
    check_eq("to_cycles", 32'(n), 32'd255);
    pop_check();
    data_req_i = 1'b0;
    tick();
    check_eq("to_err_pulse", 32'(bus_err_o), 32'd0);
    check_eq("to_ready_pulse", 32'(data_ready_o), 32'd0);
`else
    saw_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (data_ready_o || bus_err_o) saw_ready = 1'b1;
    end
    check_eq("noto_bus_req", 32'(bus_req_o), 32'd1);
    check_eq("noto_no_ready", 32'(saw_ready), 32'd0);
    rst = 1'b1; data_req_i = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("noto_rst_clear", 32'(bus_req_o), 32'd0);
`endif

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, synchronous, active-high reset), listed first.
REQ-002 SHALL have the instruction-side ports: `inst_req_i` (in, 1, level fetch request held until ready), `inst_addr_i` (in, 32), `inst_rdata_o` (out, 32), `inst_ready_o` (out, 1, one-cycle done pulse).
REQ-003 SHALL have the data-side ports: `data_req_i` (in, 1), `data_we_i` (in, 1), `data_sel_i` (in, 4, byte enables), `data_addr_i` (in, 32), `data_wdata_i` (in, 32), `data_rdata_o` (out, 32), `data_ready_o` (out, 1, pulse).
REQ-004 SHALL have the bus ports: `bus_req_o` (out, 1), `bus_we_o` (out, 1), `bus_sel_o` (out, 4), `bus_addr_o` (out, 32), `bus_wdata_o` (out, 32), `bus_rdata_i` (in, 32), `bus_ack_i` (in, 1, one-cycle completion).
REQ-005 SHALL have `flush_i` (in, 1, exception flush from pipeline control), `stallreq_o` (out, 1, to pipeline control as bus stall request) and `bus_err_o` (out, 1, timeout pulse).

Function
REQ-006 SHALL implement FSM states IDLE, DATA, INST, DONE.
REQ-007 In IDLE, SHALL grant `data_req_i` first, then `inst_req_i`: latch the address, control and wdata into registers, drive `bus_req_o`=1 from the next cycle, and enter DATA or INST; with neither request it SHALL stay in IDLE.
REQ-008 In DATA/INST, SHALL hold `bus_req_o` and all `bus_*` outputs stable until `bus_ack_i`=1 is sampled; `bus_we_o`=0 and `bus_sel_o`=4'b1111 for INST.
REQ-009 On the edge sampling `bus_ack_i`, SHALL register `bus_rdata_i` into the granted side's rdata, pulse that side's ready for exactly one cycle, clear `bus_req_o`, and enter DONE.
REQ-010 DONE SHALL last one cycle, SHALL sample no requests, and SHALL then go to IDLE; minimum request-to-ready latency is 3 cycles with zero-wait ack.
REQ-011 `stallreq_o` SHALL be combinational: (inst_req_i & ~inst_ready_o) | (data_req_i & ~data_ready_o).
REQ-012 Simultaneous inst and data requests in IDLE SHALL serve data, then inst, with one DONE cycle between them.
REQ-013 `flush_i`=1 in INST, or in the cycle INST is entered, SHALL set a discard flag; the bus transaction SHALL still complete, but `inst_ready_o` SHALL stay 0; the flag SHALL clear on entering DONE.
REQ-014 `flush_i` SHALL NOT affect DATA transactions, IDLE or DONE.
REQ-015 `data_rdata_o` and `inst_rdata_o` SHALL hold their last value between pulses.

Reset
REQ-016 On `rst`=1 at a clock edge, state SHALL be IDLE and `bus_req_o`, `inst_ready_o`, `data_ready_o`, `bus_err_o` and the discard flag SHALL be 0. All data and address outputs SHALL be 32'h0 and `bus_sel_o` SHALL be 4'b0.
REQ-017 Reset mid-transaction SHALL abandon the transfer immediately with no ready pulse; a late `bus_ack_i` in IDLE SHALL be ignored.

Configuration
REQ-018 With `BUS_TIMEOUT_EN` defined, a counter SHALL count cycles in DATA/INST. When it reaches BUS_TIMEOUT_CYCLES without ack, the block SHALL end the transaction as if acked with rdata 32'h0 and pulse `bus_err_o` for one cycle, alongside ready.
REQ-019 Without `BUS_TIMEOUT_EN`, the block SHALL wait indefinitely for ack, and `bus_err_o` SHALL be tied to 0.

Structure
REQ-020 The state enum, `Word_t`/`Bit_t`, and BUS_TIMEOUT_CYCLES (default 255, 8-bit counter) SHALL reside in the shared CPU defines package.
REQ-021 The timeout counter SHALL be a sub-module `bus_watchdog` (clk, rst, `active`, `expired` pulse), instantiated only under `BUS_TIMEOUT_EN`.

Verification
REQ-022 Read test: data read, addr 32'h8000_0010, ack 2 cycles after `bus_req_o` with rdata 32'hDEAD_BEEF -> `data_ready_o` pulses 1 cycle with `data_rdata_o`=32'hDEAD_BEEF, and `stallreq_o` is low the same cycle.
REQ-023 Simultaneous test: inst and data requests in the same cycle -> data granted first, DONE cycle, then inst; `stallreq_o` stays 1 until `inst_ready_o`.
REQ-024 Flush test: inst fetch with `flush_i` pulsed while waiting -> bus completes, no `inst_ready_o`, arbiter back in IDLE 2 cycles after ack.
REQ-025 Reset test: `rst` asserted mid-DATA -> next cycle `bus_req_o`=0, no `data_ready_o`; a later ack has no effect.
REQ-026 Timeout test (`BUS_TIMEOUT_EN`): ack never arrives -> after 255 cycles `data_ready_o`=1, `data_rdata_o`=0, `bus_err_o`=1 for one cycle; without the macro, `bus_req_o` stays 1.
REQ-027 Write test: data write with sel 4'b0011 and wdata 32'h1234_5678 -> `bus_we_o`=1, `bus_sel_o`=4'b0011, `bus_wdata_o` stable until ack.
